// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide sequencer.
// Holds the op codes, FSM states and counter width helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PREP = 2'b01,
      ITER = 2'b10,
      FIX  = 2'b11
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Shift registers plus the one shared adder/subtractor.
// mode=0 is shift-add multiply, mode=1 is restoring divide.
module muldiv_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             mode,
   input  logic [WIDTH-1:0] ld_low,
   input  logic [WIDTH-1:0] ld_opnd,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] low
);

   logic [WIDTH-1:0] acc_q, low_q, opnd_q;
   logic [WIDTH:0]   rsh, a, b;
   logic [WIDTH+1:0] sum;
   logic             no_borrow;

   always_comb begin
      rsh = {acc_q, low_q[WIDTH-1]};
      a   = mode ? rsh : {1'b0, acc_q};
      if (mode)
         b = ~{1'b0, opnd_q};
      else if (low_q[0])
         b = {1'b0, opnd_q};
      else
         b = '0;
      // subtract is a + ~b + 1; the top bit is the no-borrow flag
      sum = {1'b0, a} + {1'b0, b} + {{(WIDTH+1){1'b0}}, mode};
      no_borrow = sum[WIDTH+1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         low_q  <= '0;
         opnd_q <= '0;
      end else if (load) begin
         acc_q  <= '0;
         low_q  <= ld_low;
         opnd_q <= ld_opnd;
      end else if (step) begin
         if (mode) begin
            acc_q <= no_borrow ? sum[WIDTH-1:0] : rsh[WIDTH-1:0];
            low_q <= {low_q[WIDTH-2:0], no_borrow};
         end else begin
            acc_q <= sum[WIDTH:1];
            low_q <= {sum[0], low_q[WIDTH-1:1]};
         end
      end
   end

   assign acc = acc_q;
   assign low = low_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI and LO.
// Define MULDIV_DIVZERO_FASTPATH_EN for single-cycle divide-by-zero.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] rs_q, rt_q, hi_q, lo_q;
   logic             sgn_rs, sgn_rt, done_q, dz_q;
   logic             accept, fast, dp_load, dp_step;
   logic             signed_op, is_div, dz_cond;
   logic [WIDTH-1:0] abs_rs, abs_rt, acc, low;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;

   assign signed_op = ~op_q[0];
   assign is_div    = op_q[1];
   assign dz_cond   = is_div && (rt_q == '0);
   assign accept    = (state == IDLE) && start && !cancel;

`ifdef MULDIV_DIVZERO_FASTPATH_EN
   assign fast = accept && op[1] && (rt_val == '0);
`else
   assign fast = 1'b0;
`endif

   assign abs_rs = (signed_op && rs_q[WIDTH-1]) ? -rs_q : rs_q;
   assign abs_rt = (signed_op && rt_q[WIDTH-1]) ? -rt_q : rt_q;

   muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (dp_load),
      .step    (dp_step),
      .mode    (is_div),
      .ld_low  (is_div ? abs_rs : abs_rt),
      .ld_opnd (is_div ? abs_rt : abs_rs),
      .acc     (acc),
      .low     (low)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
      unique case (state)
         IDLE: if (accept && !fast) state_nx = PREP;
         PREP: begin
            dp_load  = 1'b1;
            state_nx = ITER;
         end
         ITER: begin
            dp_step = 1'b1;
            if (cnt == LAST) state_nx = FIX;
         end
         FIX: state_nx = IDLE;
      endcase
      if (cancel && state != IDLE) state_nx = IDLE;
   end

   always_comb begin
      prod   = {acc, low};
      res_hi = acc;
      res_lo = low;
      if (!is_div) begin
         if (signed_op && (sgn_rs ^ sgn_rt)) prod = -prod;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (dz_cond) begin
         res_hi = rs_q;
         res_lo = '1;
      end else begin
         if (sgn_rs ^ sgn_rt) res_lo = -low;
         // remainder follows the dividend's sign
         if (sgn_rs) res_hi = -acc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         op_q   <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         sgn_rs <= 1'b0;
         sgn_rt <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op;
            rs_q <= rs_val;
            rt_q <= rt_val;
         end
         if (state == PREP) begin
            cnt    <= '0;
            sgn_rs <= signed_op & rs_q[WIDTH-1];
            sgn_rt <= signed_op & rt_q[WIDTH-1];
         end else if (state == ITER) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            dz_q <= 1'b0;
            if (fast) begin
               hi_q   <= rs_val;
               lo_q   <= '1;
               done_q <= 1'b1;
               dz_q   <= 1'b1;
            end
         end else if (state == IDLE && !start) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
         end
         if (state == FIX && !cancel) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            dz_q   <= dz_cond;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, arithmetic, div-by-zero,
// cancel, HI/LO writes, ignored start while busy, and reset.
module tb_muldiv_seq;

   logic        clk, rst_n, start, cancel, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val, wdata, hi, lo;
   logic        busy, done, div_zero;

   int checks   = 0;
   int failures = 0;
   int lat, bc, nd;

`ifdef MULDIV_DIVZERO_FASTPATH_EN
   localparam int DZ_LAT  = 1;
   localparam int DZ_BUSY = 0;
`else
   localparam int DZ_LAT  = 35;
   localparam int DZ_BUSY = 34;
`endif

   muldiv_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .cancel   (cancel),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // start in cycle T; returns k where done first seen at T+k (0 = timeout)
   task automatic run(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, output int l, output int n);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      tick();
      start = 1'b0;
      l = 0; n = 0;
      for (int k = 1; k <= 60 && l == 0; k++) begin
         if (busy) n++;
         if (done) l = k;
         else tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
      hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
      rs_val = '0; rt_val = '0; wdata = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      check("rst_hilo", {hi, lo}, 64'h0);
      rst_n = 1'b1;
      tick();

      run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      check("multu_lat", lat, 35);
      check("multu_busy", bc, 34);
      check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      run(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bc);
      check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

      run(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
      check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_neg_dz", div_zero, 0);

      run(2'b11, 32'd100, 32'd0, lat, bc);
      check("dz_lat", lat, DZ_LAT);
      check("dz_busy", bc, DZ_BUSY);
      check("dz_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      check("dz_flag", div_zero, 1);

      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      check("ovf_lat", lat, 35);
      check("ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
      check("ovf_dz", div_zero, 0);

      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
      tick();
      hi_we = 1'b0; lo_we = 1'b0;
      check("mthilo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

      op = 2'b11; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      check("cxl_busy_t10", busy, 1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cxl_idle_t11", busy, 0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) nd++;
         tick();
      end
      check("cxl_nodone", nd, 0);
      check("cxl_hilo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
      lo_we = 1'b1; wdata = 32'h0000_1234;
      tick();
      lo_we = 1'b0;
      check("mtlo", {hi, lo}, 64'hCAFE_F00D_0000_1234);

      start = 1'b1; cancel = 1'b1; op = 2'b01;
      rs_val = 32'd2; rt_val = 32'd3; hi_we = 1'b1; wdata = 32'h5555;
      tick();
      start = 1'b0; cancel = 1'b0; hi_we = 1'b0;
      check("start_cxl_busy", busy, 0);
      check("start_wins_hi", hi, 32'hCAFE_F00D);

      op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; hi_we = 1'b0;
      lat = 0;
      for (int k = 6; k <= 60 && lat == 0; k++) begin
         if (done) lat = k;
         else tick();
      end
      check("bsy_lat", lat, 35);
      check("bsy_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
      tick();
      check("bsy_no_rerun", busy, 0);

      run(2'b11, 32'd5, 32'd0, lat, bc);
      check("dz2_flag", div_zero, 1);
      op = 2'b01; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
      tick();
      start = 1'b0;
      check("dz_clr_on_start", div_zero, 0);
      for (int k = 0; k < 10; k++) tick();
      check("mid_iter_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      check("mrst_outs", {busy, done, div_zero}, 0);
      check("mrst_hilo", {hi, lo}, 64'h0);
      rst_n = 1'b1;
      tick();
      run(2'b01, 32'd7, 32'd6, lat, bc);
      check("post_rst_mult", {hi, lo}, 64'd42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
